// File: rtl/bus_arb_pkg.sv
// Shared types and widths for the CPU/DMA memory bus arbiter.
package bus_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  // Wide enough for a burst limit of up to 15 transfers.
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ARB_CPU,
    ARB_GRANT,
    ARB_RELEASE
  } arb_state_t;

  // One bus master's view of the memory interface.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rnw;
  } bus_req_t;

endpackage

// File: rtl/bus_arb_mux.sv
// Combinational 2:1 selector for the address, write-data and direction fields.
module bus_arb_mux
  import bus_arb_pkg::*;
(
  input  logic     sel,
  input  bus_req_t cpu,
  input  bus_req_t dma,
  output bus_req_t mem
);

  // The DMA port drives memory only while it holds the grant.
  assign mem = sel ? dma : cpu;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between the CPU and a DMA/loader port. The DMA steals
// the bus only during CPU read cycles (stalling the CPU through ready), runs
// up to MAX_BURST transfers, then hands the bus back for at least one CPU cycle.
module mem_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [7:0]        cpu_addr_high,
  input  logic [7:0]        cpu_addr_low,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic              cpu_rnw,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_data_in,
  input  logic              dma_req,
  input  logic              dma_rnw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_grant,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rnw,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

  arb_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic             holdoff, holdoff_next;
  logic             xfer;

  bus_req_t cpu_bus, dma_bus, mem_bus;

  assign cpu_bus = '{addr: {cpu_addr_high, cpu_addr_low}, wdata: cpu_data_out, rnw: cpu_rnw};
  assign dma_bus = '{addr: dma_addr, wdata: dma_wdata, rnw: dma_rnw};

  bus_arb_mux u_mux (
    .sel (dma_grant),
    .cpu (cpu_bus),
    .dma (dma_bus),
    .mem (mem_bus)
  );

  assign mem_addr    = mem_bus.addr;
  assign mem_wdata   = mem_bus.wdata;
  assign mem_rnw     = mem_bus.rnw;
  assign cpu_data_in = mem_rdata;
  assign dma_grant   = (state == ARB_GRANT);
  assign cpu_ready   = (state != ARB_GRANT);

  // Saturating increment: the burst count never wraps past the limit.
  assign cnt_inc = (cnt == BURST_LIMIT) ? cnt : cnt + 1'b1;

  // Next-state, burst count, holdoff and transfer strobe.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next   = state;
    cnt_next     = cnt;
    holdoff_next = holdoff;
    xfer         = 1'b0;
    case (state)
      ARB_CPU: begin
        holdoff_next = 1'b0;
        // A CPU write cannot be stalled, so only a read cycle is stolen.
        if (dma_req && cpu_rnw && !holdoff) begin
          state_next = ARB_GRANT;
          cnt_next   = '0;
        end
      end
      ARB_GRANT: begin
        if (dma_req) begin
          xfer     = 1'b1;
          cnt_next = cnt_inc;
          if (cnt_inc == BURST_LIMIT) state_next = ARB_RELEASE;
        end else begin
          state_next = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        // Guarantees a full CPU cycle before the DMA can win again.
        holdoff_next = 1'b1;
        state_next   = ARB_CPU;
      end
      default: state_next = ARB_CPU;
    endcase
  end

  // State, counter and holdoff registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= ARB_CPU;
      cnt     <= '0;
      holdoff <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state   <= state_next;
      cnt     <= cnt_next;
      holdoff <= holdoff_next;
    end
  end

  // Acknowledge each transfer one cycle later, with read data captured then.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
    end else begin
      dma_ack <= xfer;
      if (xfer && dma_rnw) dma_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  cpu_addr_high, cpu_addr_low, cpu_data_out;
  logic        cpu_rnw;
  logic        cpu_ready;
  logic [7:0]  cpu_data_in;
  logic        dma_req, dma_rnw;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_grant, dma_ack;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rnw;
  logic [7:0]  mem_rdata;

  mem_bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .nrst(nrst),
    .cpu_addr_high(cpu_addr_high), .cpu_addr_low(cpu_addr_low),
    .cpu_data_out(cpu_data_out), .cpu_rnw(cpu_rnw),
    .cpu_ready(cpu_ready), .cpu_data_in(cpu_data_in),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_grant(dma_grant), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rnw(mem_rnw), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT, written only through the DUT's bus.
  logic [7:0] ram  [0:65535];
  // Model's own picture of what memory should hold.
  logic [7:0] mram [0:65535];

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (!mem_rnw) ram[mem_addr] <= mem_wdata;

  int tests = 0;
  int fails = 0;

  // Model: who owns the bus, how many transfers this grant, release/holdoff.
  bit         m_dma, m_rel, m_hold, m_ack, xfer_seen;
  int         m_cnt;
  logic [7:0] m_rdata;
  int         run = 0;
  int         last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_addr();
    return m_dma ? dma_addr : {cpu_addr_high, cpu_addr_low};
  endfunction

  task automatic model_reset();
    m_dma = 0; m_rel = 0; m_hold = 0; m_ack = 0; m_cnt = 0; m_rdata = 8'h00;
  endtask

  task automatic compare();
    logic [15:0] ea;
    ea = exp_addr();
    check("cpu_ready", cpu_ready, !m_dma);
    check("dma_grant", dma_grant, m_dma);
    check("dma_ack", dma_ack, m_ack);
    if (m_ack) check("dma_rdata", dma_rdata, m_rdata);
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, m_dma ? dma_wdata : cpu_data_out);
    check("mem_rnw", mem_rnw, m_dma ? dma_rnw : cpu_rnw);
    check("cpu_data_in", cpu_data_in, mram[ea]);
    if (m_dma) run++;
    else if (run > 0) begin
      check("stall_le_max", run <= MAX_BURST + 1, 1'b1);
      last_run = run;
      run = 0;
    end
  endtask

  task automatic model_edge();
    logic [15:0] ea;
    xfer_seen = 0;
    if (!nrst) begin
      model_reset();
      return;
    end
    ea = exp_addr();
    if (!(m_dma ? dma_rnw : cpu_rnw)) mram[ea] = m_dma ? dma_wdata : cpu_data_out;
    m_ack = 0;
    if (m_rel) begin
      m_rel = 0; m_hold = 1;
    end else if (m_dma) begin
      if (dma_req) begin
        m_cnt++; m_ack = 1; xfer_seen = 1;
        if (dma_rnw) m_rdata = mram[dma_addr];
      end
      if (!dma_req || m_cnt == MAX_BURST) begin
        m_dma = 0; m_rel = 1;
      end
    end else begin
      if (dma_req && cpu_rnw && !m_hold) begin
        m_dma = 1; m_cnt = 0;
      end
      m_hold = 0;
    end
  endtask

  // One cycle: compare mid-cycle, advance model on the edge, return 1 after it.
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cpu_at(input logic [15:0] a, input logic rnw, input logic [7:0] d);
    {cpu_addr_high, cpu_addr_low} = a;
    cpu_rnw = rnw;
    cpu_data_out = d;
  endtask

  initial begin
    int k, gap, first_burst, remaining;
    bit seen;
    for (int a = 0; a < 65536; a++) begin
      ram[a]  = 8'(a) ^ 8'(a >> 8);
      mram[a] = 8'(a) ^ 8'(a >> 8);
    end
    ram[16'hFFFC] = 8'hDD; mram[16'hFFFC] = 8'hDD;
    ram[16'hFFFD] = 8'hCC; mram[16'hFFFD] = 8'hCC;
    ram[16'h0100] = 8'hFF; mram[16'h0100] = 8'hFF;

    nrst = 0; dma_req = 0; dma_rnw = 1; dma_addr = 16'h0; dma_wdata = 8'h0;
    cpu_at(16'hFFFC, 1'b1, 8'h00);
    model_reset();
    tick(); tick();
    check("rst_ready", cpu_ready, 1'b1);
    check("rst_grant", dma_grant, 1'b0);
    check("rst_ack", dma_ack, 1'b0);
    check("rst_rdata", dma_rdata, 8'h00);
    nrst = 1;

    // Boot vector fetch with no DMA activity.
    cpu_at(16'hFFFC, 1'b1, 8'h00); #1;
    check("boot_lo", cpu_data_in, 8'hDD);
    tick();
    cpu_at(16'hFFFD, 1'b1, 8'h00); #1;
    check("boot_hi", cpu_data_in, 8'hCC);
    tick();
    cpu_at(16'hCCDD, 1'b1, 8'h00); #1;
    check("boot_fetch_addr", mem_addr, 16'hCCDD);
    check("boot_ready", cpu_ready, 1'b1);
    tick(); tick();

    // Single DMA read stealing a CPU read cycle.
    cpu_at(16'h1234, 1'b1, 8'h00);
    dma_req = 1; dma_rnw = 1; dma_addr = 16'h0100;
    tick();
    check("t2_grant", dma_grant, 1'b1);
    check("t2_stall", cpu_ready, 1'b0);
    tick();
    check("t2_ack", dma_ack, 1'b1);
    check("t2_rdata", dma_rdata, 8'hFF);
    dma_req = 0;
    tick();
    check("t2_release_grant", dma_grant, 1'b0);
    check("t2_release_ready", cpu_ready, 1'b1);
    check("t2_release_ack", dma_ack, 1'b0);
    check("t2_reread_addr", mem_addr, 16'h1234);
    tick();
    check("t2_stall_len", last_run, 2);
    tick(); tick();

    // Request during a CPU write is held off until a read cycle.
    cpu_at(16'hCD31, 1'b0, 8'h41);
    dma_req = 1; dma_rnw = 1; dma_addr = 16'h0105;
    tick();
    check("t3_no_grant0", dma_grant, 1'b0);
    check("t3_write_landed", ram[16'hCD31], 8'h41);
    tick();
    check("t3_no_grant1", dma_grant, 1'b0);
    cpu_at(16'hCD32, 1'b1, 8'h00);
    tick();
    check("t3_grant_on_read", dma_grant, 1'b1);
    dma_req = 0;
    tick(); tick(); tick();

    // Held request writing eight bytes: two bursts of MAX_BURST.
    cpu_at(16'h0200, 1'b1, 8'h00);
    k = 0; gap = 0; first_burst = -1; seen = 0;
    dma_req = 1; dma_rnw = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      dma_addr = 16'h0300 + 16'(k);
      dma_wdata = 8'hA0 + 8'(k);
      tick();
      if (xfer_seen) k++;
      if (dma_grant) seen = 1;
      if (seen && !dma_grant && k > 0 && k < 8) begin
        if (first_burst < 0) first_burst = k;
        gap++;
      end
    end
    check("t4_done", k, 8);
    dma_req = 0;
    check("t4_first_burst", first_burst, MAX_BURST);
    check("t4_gap", gap, 3);
    tick(); tick();
    for (int i = 0; i < 8; i++) check("t4_mem", ram[16'h0300 + i], 8'hA0 + 8'(i));
    tick(); tick();

    // Asynchronous reset in the middle of a burst.
    dma_req = 1; dma_rnw = 1; dma_addr = 16'h0110;
    k = 0;
    while (!dma_grant && k < 10) begin tick(); k++; end
    check("t5_granted", dma_grant, 1'b1);
    tick();
    #2 nrst = 0;
    #1;
    check("t5_rst_ready", cpu_ready, 1'b1);
    check("t5_rst_grant", dma_grant, 1'b0);
    check("t5_rst_ack", dma_ack, 1'b0);
    model_reset();
    dma_req = 0;
    tick(); tick();
    nrst = 1;
    cpu_at(16'hFFFC, 1'b1, 8'h00);
    tick();
    check("t5_reboot", cpu_data_in, 8'hDD);
    tick(); tick();

    // One-shot request: a single transfer, an ack, then release.
    cpu_at(16'h0208, 1'b1, 8'h00);
    dma_req = 1; dma_rnw = 1; dma_addr = 16'h0101;
    tick(); tick();
    dma_req = 0;
    check("t6_ack", dma_ack, 1'b1);
    check("t6_rdata", dma_rdata, mram[16'h0101]);
    tick();
    check("t6_released", dma_grant, 1'b0);
    tick(); tick();

    // Randomized traffic against the model.
    remaining = 0;
    for (int c = 0; c < 3000; c++) begin
      cpu_at(16'h0100 + 16'($urandom_range(0, 31)), ($urandom % 4) != 0, 8'($urandom));
      if (remaining == 0 && ($urandom % 6) == 0) remaining = $urandom_range(1, 7);
      if (remaining > 0 && ($urandom % 12) == 0) remaining = 0;
      dma_req = (remaining > 0);
      dma_rnw = $urandom % 2;
      dma_addr = 16'h0100 + 16'($urandom_range(0, 31));
      dma_wdata = 8'($urandom);
      tick();
      if (xfer_seen && remaining > 0) remaining--;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
